bcd_scan_counter: RTL and testbench



---
 rtl/bcd_scan_counter.sv | 87 ++++++++
 tb/tb_bcd_scan_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: DIGITS-wide BCD up/down counter with time-multiplexed active-low 7-segment drive.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_scan_counter #(
  parameter int DIGITS = 4,
  parameter int COUNT_DIV_W = 24,
  parameter int SCAN_DIV_W = 12
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [4*DIGITS-1:0]   DIP,
  input  logic                  UP_DOWN,
  input  logic                  LOAD,
  input  logic                  PAUSE,
  output logic [7:0]            SEGMENT,
  output logic [DIGITS-1:0]     ENABLE,
  output logic                  WRAP
);
  localparam int IW = $clog2(DIGITS);
  logic [COUNT_DIV_W-1:0] cdiv;
  logic [SCAN_DIV_W-1:0]  sdiv;
  logic [4*DIGITS-1:0]    cnt, pre, nxt;
  logic [DIGITS:0]        cy;
  logic [3:0]             dig [DIGITS];
  logic [IW-1:0]          idx, idx_nxt;
  logic [3:0]             cur;
  logic                   blank;
  logic                   count_tick, scan_tick;
  assign count_tick = &cdiv;
  assign scan_tick  = &sdiv;
  assign cy[0] = 1'b1;
  // cy[DIGITS] set means every digit is at its terminal value for the current direction
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign dig[i] = cnt[4*i +: 4];
    assign pre[4*i +: 4] = DIP[4*i +: 4] > 4'd9 ? 4'd0 : DIP[4*i +: 4];
    assign nxt[4*i +: 4] = !cy[i] ? dig[i] :
                           UP_DOWN ? (dig[i] == 4'd9 ? 4'd0 : dig[i] + 4'd1) :
                                     (dig[i] == 4'd0 ? 4'd9 : dig[i] - 4'd1);
    assign cy[i+1] = cy[i] & (UP_DOWN ? dig[i] == 4'd9 : dig[i] == 4'd0);
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    assign lz[i] = (i != 0) && (cnt[4*DIGITS-1:4*i] == '0);
  end
  assign blank = lz[idx];
`else
  assign blank = 1'b0;
`endif
  assign idx_nxt = idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
  assign cur = dig[idx];
  always_comb begin
    case (cur)
      4'd0: SEGMENT = 8'hC0;
      4'd1: SEGMENT = 8'hF9;
      4'd2: SEGMENT = 8'hA4;
      4'd3: SEGMENT = 8'hB0;
      4'd4: SEGMENT = 8'h99;
      4'd5: SEGMENT = 8'h92;
      4'd6: SEGMENT = 8'h82;
      4'd7: SEGMENT = 8'hF8;
      4'd8: SEGMENT = 8'h80;
      4'd9: SEGMENT = 8'h90;
      default: SEGMENT = 8'hFF;
    endcase
    if (blank) SEGMENT = 8'hFF;
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cdiv   <= '0;
      sdiv   <= '0;
      cnt    <= pre;
      idx    <= '0;
      ENABLE <= ~DIGITS'(1);
      WRAP   <= 1'b0;
    end else begin
      sdiv <= sdiv + SCAN_DIV_W'(1);
      if (scan_tick) begin
        idx    <= idx_nxt;
        ENABLE <= ~(DIGITS'(1) << idx_nxt);
      end
      cdiv <= LOAD ? '0 : cdiv + COUNT_DIV_W'(1);
      WRAP <= !LOAD && !PAUSE && count_tick && cy[DIGITS];
      if (LOAD) cnt <= pre;
      else if (!PAUSE && count_tick) cnt <= cy[DIGITS] ? pre : nxt;
    end
  end
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: randomized and directed checks of bcd_scan_counter against an integer-valued reference model.
module tb_bcd_scan_counter;
  localparam int D = 4;
  localparam logic [7:0] CODES [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic CLK = 1'b0, RESET = 1'b0, UP_DOWN = 1'b1, LOAD = 1'b0, PAUSE = 1'b0;
  logic [15:0] DIP = 16'h1A93;
  logic [7:0] SEGMENT;
  logic [3:0] ENABLE;
  logic WRAP;
  int total = 0, bad = 0;
  int m_cdiv = 0, m_sdiv = 0, m_val = 0, m_idx = 0;
  logic m_wrap = 1'b0;

  bcd_scan_counter #(.DIGITS(4), .COUNT_DIV_W(4), .SCAN_DIV_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .DIP(DIP), .UP_DOWN(UP_DOWN), .LOAD(LOAD), .PAUSE(PAUSE),
    .SEGMENT(SEGMENT), .ENABLE(ENABLE), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  function automatic int pow10(int n);
    int r = 1;
    for (int i = 0; i < n; i++) r *= 10;
    return r;
  endfunction

  function automatic int pre_val(logic [15:0] dip);
    int v = 0;
    for (int i = 0; i < D; i++) begin
      int n = int'(dip[4*i +: 4]);
      if (n > 9) n = 0;
      v += n * pow10(i);
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_seg(int val, int pos);
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && val < pow10(pos)) return 8'hFF;
`endif
    return CODES[(val / pow10(pos)) % 10];
  endfunction

  function automatic logic [12:0] expv();
    logic [3:0] e = 4'hF;
    e[m_idx] = 1'b0;
    return {exp_seg(m_val, m_idx), e, m_wrap};
  endfunction

  task automatic step();
    bit st, ct;
    @(posedge CLK);
    if (!RESET) begin
      m_cdiv = 0; m_sdiv = 0; m_val = pre_val(DIP); m_idx = 0; m_wrap = 1'b0;
    end else begin
      st = (m_sdiv == 3);
      m_sdiv = (m_sdiv + 1) % 4;
      if (st) m_idx = (m_idx + 1) % D;
      ct = (m_cdiv == 15);
      m_wrap = 1'b0;
      if (LOAD) begin
        m_val = pre_val(DIP);
        m_cdiv = 0;
      end else begin
        m_cdiv = (m_cdiv + 1) % 16;
        if (!PAUSE && ct) begin
          if (UP_DOWN) begin
            if (m_val == pow10(D) - 1) begin m_val = pre_val(DIP); m_wrap = 1'b1; end
            else m_val++;
          end else begin
            if (m_val == 0) begin m_val = pre_val(DIP); m_wrap = 1'b1; end
            else m_val--;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0; DIP = 16'h1A93; LOAD = 1'b0; PAUSE = 1'b0; UP_DOWN = 1'b1;
    step(); step();
    total++;
    if ({SEGMENT, ENABLE, WRAP} !== {8'hB0, 4'b1110, 1'b0}) begin
      bad++; $display("FAIL reset_const got=%h exp=%h", {SEGMENT, ENABLE, WRAP}, {8'hB0, 4'b1110, 1'b0});
    end
    total++;
    if ({SEGMENT, ENABLE, WRAP} !== expv()) begin
      bad++; $display("FAIL reset_model got=%h exp=%h", {SEGMENT, ENABLE, WRAP}, expv());
    end
    RESET = 1'b1;
  endtask

  task automatic test_count_up();
    int wraps = 0;
    DIP = 16'h9998; UP_DOWN = 1'b1; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      wraps += int'(WRAP);
      total++;
      if ({SEGMENT, ENABLE, WRAP} !== expv()) begin
        bad++; $display("FAIL count_up c=%0d got=%h exp=%h", c, {SEGMENT, ENABLE, WRAP}, expv());
      end
    end
    total++;
    if (wraps !== 1) begin bad++; $display("FAIL up_wrap_count got=%0d exp=1", wraps); end
  endtask

  task automatic test_count_down();
    int wraps = 0;
    DIP = 16'h0100; UP_DOWN = 1'b0; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      total++;
      if ({SEGMENT, ENABLE, WRAP} !== expv()) begin
        bad++; $display("FAIL count_down c=%0d got=%h exp=%h", c, {SEGMENT, ENABLE, WRAP}, expv());
      end
    end
    DIP = 16'h0001; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      wraps += int'(WRAP);
      total++;
      if ({SEGMENT, ENABLE, WRAP} !== expv()) begin
        bad++; $display("FAIL down_wrap c=%0d got=%h exp=%h", c, {SEGMENT, ENABLE, WRAP}, expv());
      end
    end
    total++;
    if (wraps !== 1) begin bad++; $display("FAIL down_wrap_count got=%0d exp=1", wraps); end
  endtask

  task automatic test_pause();
    UP_DOWN = 1'b1; PAUSE = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      total++;
      if ({SEGMENT, ENABLE, WRAP} !== expv()) begin
        bad++; $display("FAIL pause c=%0d got=%h exp=%h", c, {SEGMENT, ENABLE, WRAP}, expv());
      end
    end
    DIP = 16'h5678; LOAD = 1'b1;
    step();
    total++;
    if ({SEGMENT, ENABLE, WRAP} !== expv()) begin
      bad++; $display("FAIL load_pause got=%h exp=%h", {SEGMENT, ENABLE, WRAP}, expv());
    end
    LOAD = 1'b0; PAUSE = 1'b0;
  endtask

  task automatic test_reset_priority();
    int guard = 0;
    while (m_cdiv != 15 && guard < 20) begin step(); guard++; end
    total++;
    if (guard >= 20) begin bad++; $display("FAIL prio_wait got=%0d exp=15", m_cdiv); end
    DIP = 16'h2468; RESET = 1'b0; LOAD = 1'b1;
    step();
    total++;
    if ({SEGMENT, ENABLE, WRAP} !== {8'h80, 4'b1110, 1'b0}) begin
      bad++; $display("FAIL reset_prio got=%h exp=%h", {SEGMENT, ENABLE, WRAP}, {8'h80, 4'b1110, 1'b0});
    end
    RESET = 1'b1; LOAD = 1'b0;
  endtask

  task automatic test_blank();
    logic [7:0] hi;
`ifdef LEADING_ZERO_BLANK_EN
    hi = 8'hFF;
`else
    hi = 8'hC0;
`endif
    DIP = 16'h0042; LOAD = 1'b1;
    step();
    LOAD = 1'b0; PAUSE = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      total++;
      if ({SEGMENT, ENABLE, WRAP} !== expv()) begin
        bad++; $display("FAIL blank c=%0d got=%h exp=%h", c, {SEGMENT, ENABLE, WRAP}, expv());
      end
      if (m_idx >= 2) begin
        total++;
        if (SEGMENT !== hi) begin bad++; $display("FAIL blank_hi idx=%0d got=%h exp=%h", m_idx, SEGMENT, hi); end
      end
    end
    PAUSE = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      DIP     = 16'($urandom);
      UP_DOWN = 1'($urandom_range(0, 1));
      LOAD    = $urandom_range(0, 40) == 0;
      PAUSE   = $urandom_range(0, 5) == 0;
      RESET   = $urandom_range(0, 150) != 0;
      step();
      total++;
      if ({SEGMENT, ENABLE, WRAP} !== expv()) begin
        bad++; $display("FAIL random c=%0d got=%h exp=%h", c, {SEGMENT, ENABLE, WRAP}, expv());
      end
    end
    RESET = 1'b1; LOAD = 1'b0; PAUSE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_pause();
    test_reset_priority();
    test_blank();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
